// File: rtl/pe_loop_sequencer.sv
// Per-PE loop sequencer: walks the W/S/C/M convolution loop nest for one tile
// and issues input-pad, weight-pad and psum-pad addresses with psum init/last
// flags. A two-stage tag pipeline (mult, sum) lines the psum write-back up
// with the arithmetic datapath.
module pe_loop_sequencer #(
  parameter int CFG_W   = 4,
  parameter int IPAD_AW = 5,
  parameter int WPAD_AW = 7,
  parameter int PPAD_AW = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CFG_W-1:0]   i_cfg_w,
  input  logic [CFG_W-1:0]   i_cfg_s,
  input  logic [CFG_W-1:0]   i_cfg_c,
  input  logic [CFG_W-1:0]   i_cfg_m,
  output logic               o_iss_valid,
  input  logic               i_iss_ready,
  output logic [IPAD_AW-1:0] o_ip_addr,
  output logic [WPAD_AW-1:0] o_wp_addr,
  output logic [PPAD_AW-1:0] o_pp_addr,
  output logic               o_ps_init,
  output logic               o_ps_last,
  output logic               o_ss_valid,
  output logic [PPAD_AW-1:0] o_ss_pp_addr,
  output logic               o_ss_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  // Wide enough that no product of three loop bounds (or the pad limits) truncates.
  localparam int XW = 3 * CFG_W + IPAD_AW + WPAD_AW + 2;
  localparam logic [XW-1:0] IP_LIMIT = XW'(1) << IPAD_AW;
  localparam logic [XW-1:0] WP_LIMIT = XW'(1) << WPAD_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_reg;
  logic   drain_reg;
  logic   err_reg;

  // Latched loop bounds and the live loop counters.
  logic [CFG_W-1:0] w_cfg_reg, s_cfg_reg, c_cfg_reg, m_cfg_reg;
  logic [CFG_W-1:0] w_reg, s_reg, c_reg, m_reg;

  // Tag pipeline: ms = multiply stage, ss = sum stage.
  logic               ms_valid_reg, ss_valid_reg;
  logic [PPAD_AW-1:0] ms_pp_reg, ss_pp_reg;
  logic               ms_last_reg, ss_last_reg;

  logic [XW-1:0] ip_need, wp_need;
  logic          cfg_bad;
  logic          running, fire;
  logic          w_wrap, s_wrap, c_wrap, m_wrap, last_issue;

  // Legality of the offered configuration, evaluated at full width.
  always_comb begin
    ip_need = (XW'(i_cfg_w) + XW'(i_cfg_s) - XW'(1)) * XW'(i_cfg_c);
    wp_need = XW'(i_cfg_s) * XW'(i_cfg_c) * XW'(i_cfg_m);
    cfg_bad = (i_cfg_w == '0) || (i_cfg_s == '0) || (i_cfg_c == '0) || (i_cfg_m == '0)
              || (ip_need > IP_LIMIT) || (wp_need > WP_LIMIT);
  end

  assign running    = (state_reg == ST_RUN);
  assign fire       = running && i_iss_ready;
  assign m_wrap     = (m_reg == m_cfg_reg - CFG_W'(1));
  assign c_wrap     = (c_reg == c_cfg_reg - CFG_W'(1));
  assign s_wrap     = (s_reg == s_cfg_reg - CFG_W'(1));
  assign w_wrap     = (w_reg == w_cfg_reg - CFG_W'(1));
  assign last_issue = w_wrap && s_wrap && c_wrap && m_wrap;

  // Addresses follow straight from the counters; flags are gated so idle reads as zero.
  assign o_ip_addr = IPAD_AW'((XW'(w_reg) + XW'(s_reg)) * XW'(c_cfg_reg) + XW'(c_reg));
  assign o_wp_addr = WPAD_AW'((XW'(s_reg) * XW'(c_cfg_reg) + XW'(c_reg)) * XW'(m_cfg_reg)
                              + XW'(m_reg));
  assign o_pp_addr = PPAD_AW'(m_reg);
  assign o_ps_init = running && (s_reg == '0) && (c_reg == '0);
  assign o_ps_last = running && s_wrap && c_wrap;

  assign o_cfg_ready  = (state_reg == ST_IDLE);
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_iss_valid  = running;
  assign o_done       = (state_reg == ST_DONE);
  assign o_err        = err_reg;
  assign o_ss_valid   = ss_valid_reg;
  assign o_ss_pp_addr = ss_pp_reg;
  assign o_ss_last    = ss_last_reg;

  // Control FSM: config acceptance, loop-nest counting, drain and done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      drain_reg <= 1'b0;
      err_reg   <= 1'b0;
      w_cfg_reg <= '0;
      s_cfg_reg <= '0;
      c_cfg_reg <= '0;
      m_cfg_reg <= '0;
      w_reg     <= '0;
      s_reg     <= '0;
      c_reg     <= '0;
      m_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            if (cfg_bad) begin
              err_reg <= 1'b1;
            end else begin
              err_reg   <= 1'b0;
              w_cfg_reg <= i_cfg_w;
              s_cfg_reg <= i_cfg_s;
              c_cfg_reg <= i_cfg_c;
              m_cfg_reg <= i_cfg_m;
              w_reg     <= '0;
              s_reg     <= '0;
              c_reg     <= '0;
              m_reg     <= '0;
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (fire) begin
            // Innermost counter wraps and carries outward; the final issue
            // leaves every counter back at zero.
            if (m_wrap) begin
              m_reg <= '0;
              if (c_wrap) begin
                c_reg <= '0;
                if (s_wrap) begin
                  s_reg <= '0;
                  w_reg <= w_wrap ? '0 : w_reg + CFG_W'(1);
                end else begin
                  s_reg <= s_reg + CFG_W'(1);
                end
              end else begin
                c_reg <= c_reg + CFG_W'(1);
              end
            end else begin
              m_reg <= m_reg + CFG_W'(1);
            end
            if (last_issue) begin
              state_reg <= ST_DRAIN;
              drain_reg <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles lets the last tag leave the sum stage.
          drain_reg <= ~drain_reg;
          if (drain_reg) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag pipeline shifts every cycle; a non-accepted cycle inserts a zero bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ms_valid_reg <= 1'b0;
      ms_pp_reg    <= '0;
      ms_last_reg  <= 1'b0;
      ss_valid_reg <= 1'b0;
      ss_pp_reg    <= '0;
      ss_last_reg  <= 1'b0;
    end else begin
      ms_valid_reg <= fire;
      ms_pp_reg    <= fire ? o_pp_addr : '0;
      ms_last_reg  <= fire && o_ps_last;
      ss_valid_reg <= ms_valid_reg;
      ss_pp_reg    <= ms_pp_reg;
      ss_last_reg  <= ms_last_reg;
    end
  end

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Self-checking bench for pe_loop_sequencer: directed tiles, stalls, illegal
// configs, mid-tile reset and randomized tiles against a loop-nest model.
module tb_pe_loop_sequencer;

  localparam int CFG_W   = 4;
  localparam int IPAD_AW = 5;
  localparam int WPAD_AW = 7;
  localparam int PPAD_AW = 4;
  localparam int BUDGET  = 6000;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CFG_W-1:0]   cfg_w, cfg_s, cfg_c, cfg_m;
  logic               iss_valid;
  logic               iss_ready;
  logic [IPAD_AW-1:0] ip_addr;
  logic [WPAD_AW-1:0] wp_addr;
  logic [PPAD_AW-1:0] pp_addr;
  logic               ps_init, ps_last;
  logic               ss_valid;
  logic [PPAD_AW-1:0] ss_pp_addr;
  logic               ss_last;
  logic               busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int ip;
    int wp;
    int pp;
    int init;
    int last;
  } iss_t;

  iss_t exp_q[$];
  int   acc_idx[0:BUDGET];

  always #5 clk = ~clk;

  pe_loop_sequencer #(
    .CFG_W(CFG_W), .IPAD_AW(IPAD_AW), .WPAD_AW(WPAD_AW), .PPAD_AW(PPAD_AW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_w(cfg_w), .i_cfg_s(cfg_s), .i_cfg_c(cfg_c), .i_cfg_m(cfg_m),
    .o_iss_valid(iss_valid), .i_iss_ready(iss_ready),
    .o_ip_addr(ip_addr), .o_wp_addr(wp_addr), .o_pp_addr(pp_addr),
    .o_ps_init(ps_init), .o_ps_last(ps_last),
    .o_ss_valid(ss_valid), .o_ss_pp_addr(ss_pp_addr), .o_ss_last(ss_last),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected issue sequence straight from the loop nest definition.
  function automatic void build_q(input int w, input int s, input int c, input int m);
    iss_t e;
    exp_q.delete();
    for (int wi = 0; wi < w; wi++)
      for (int si = 0; si < s; si++)
        for (int ci = 0; ci < c; ci++)
          for (int mi = 0; mi < m; mi++) begin
            e.ip   = (wi + si) * c + ci;
            e.wp   = (si * c + ci) * m + mi;
            e.pp   = mi;
            e.init = (si == 0 && ci == 0) ? 1 : 0;
            e.last = (si == s - 1 && ci == c - 1) ? 1 : 0;
            exp_q.push_back(e);
          end
  endfunction

  function automatic bit legal(input int w, input int s, input int c, input int m);
    return (w > 0) && (s > 0) && (c > 0) && (m > 0)
           && ((w + s - 1) * c <= (1 << IPAD_AW)) && (s * c * m <= (1 << WPAD_AW));
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_iss_valid"}, 32'(iss_valid), 0);
    chk({tag, "_ip"}, 32'(ip_addr), 0);
    chk({tag, "_wp"}, 32'(wp_addr), 0);
    chk({tag, "_pp"}, 32'(pp_addr), 0);
    chk({tag, "_init"}, 32'(ps_init), 0);
    chk({tag, "_last"}, 32'(ps_last), 0);
    chk({tag, "_ss_valid"}, 32'(ss_valid), 0);
    chk({tag, "_ss_pp"}, 32'(ss_pp_addr), 0);
    chk({tag, "_ss_last"}, 32'(ss_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic drive_cfg(input int w, input int s, input int c, input int m);
    cfg_valid = 1'b1;
    cfg_w = CFG_W'(w);
    cfg_s = CFG_W'(s);
    cfg_c = CFG_W'(c);
    cfg_m = CFG_W'(m);
  endtask

  // One full tile, entered and left at a falling edge with the DUT idle.
  task automatic run_tile(input int w, input int s, input int c, input int m,
                          input int stall_pct, input int stall_after, input bit hold);
    int total, idx, last_acc, stall_left, n;
    bit finished, exp_valid, exp_ss, in_idle, acc;
    build_q(w, s, c, m);
    total = exp_q.size();
    chk("tile_cfg_ready", 32'(cfg_ready), 1);
    drive_cfg(w, s, c, m);
    @(negedge clk);
    if (!hold) cfg_valid = 1'b0;
    chk("tile_err_clear", 32'(err), 0);
    idx = 0; last_acc = -1; stall_left = 0; n = 1; finished = 1'b0;
    acc_idx[0] = -1;
    while (n < BUDGET && !finished) begin
      exp_valid = (idx < total);
      chk("iss_valid", 32'(iss_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("ip_addr", 32'(ip_addr), exp_q[idx].ip);
        chk("wp_addr", 32'(wp_addr), exp_q[idx].wp);
        chk("pp_addr", 32'(pp_addr), exp_q[idx].pp);
        chk("ps_init", 32'(ps_init), exp_q[idx].init);
        chk("ps_last", 32'(ps_last), exp_q[idx].last);
      end
      exp_ss = (n >= 3) && (acc_idx[n-2] >= 0);
      chk("ss_valid", 32'(ss_valid), 32'(exp_ss));
      if (exp_ss) begin
        chk("ss_pp_addr", 32'(ss_pp_addr), exp_q[acc_idx[n-2]].pp);
        chk("ss_last", 32'(ss_last), exp_q[acc_idx[n-2]].last);
      end
      chk("done", 32'(done), 32'(last_acc > 0 && n == last_acc + 3));
      in_idle = (last_acc > 0) && (n >= last_acc + 4);
      chk("busy", 32'(busy), 32'(!in_idle));
      chk("cfg_ready", 32'(cfg_ready), 32'(in_idle));
      if (in_idle) begin
        finished = 1'b1;
      end else begin
        if (stall_left > 0) begin
          iss_ready = 1'b0;
          stall_left--;
        end else begin
          iss_ready = ($urandom_range(99) >= stall_pct);
        end
        acc = exp_valid && iss_ready;
        acc_idx[n] = acc ? idx : -1;
        if (acc) begin
          idx++;
          if (idx == total) last_acc = n;
          if (idx == stall_after) stall_left = 3;
        end
        @(negedge clk);
        n++;
      end
    end
    chk("tile_finished", 32'(finished), 1);
    $display("tile W=%0d S=%0d C=%0d M=%0d issues=%0d cycles=%0d", w, s, c, m, idx, n);
  endtask

  // Illegal configuration: sticky error, nothing issued, stays idle.
  task automatic run_bad(input int w, input int s, input int c, input int m);
    chk("bad_cfg_ready", 32'(cfg_ready), 1);
    drive_cfg(w, s, c, m);
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bad_err", 32'(err), 1);
      chk("bad_busy", 32'(busy), 0);
      chk("bad_iss_valid", 32'(iss_valid), 0);
      chk("bad_done", 32'(done), 0);
      chk("bad_cfg_ready", 32'(cfg_ready), 1);
      @(negedge clk);
    end
    $display("bad cfg W=%0d S=%0d C=%0d M=%0d rejected", w, s, c, m);
  endtask

  // Reset pulsed after five accepted issues.
  task automatic run_abort(input int w, input int s, input int c, input int m);
    build_q(w, s, c, m);
    drive_cfg(w, s, c, m);
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abort_iss_valid", 32'(iss_valid), 1);
      chk("abort_ip", 32'(ip_addr), exp_q[k].ip);
      chk("abort_wp", 32'(wp_addr), exp_q[k].wp);
      iss_ready = 1'b1;
      @(negedge clk);
    end
    chk("abort_busy_before", 32'(busy), 1);
    iss_ready = 1'b0;
    rst = 1'b1;
    #1;
    reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", 32'(done), 0);
      chk("abort_idle", 32'(busy), 0);
      chk("abort_ss_valid", 32'(ss_valid), 0);
      @(negedge clk);
    end
    $display("abort W=%0d S=%0d C=%0d M=%0d after 5 issues", w, s, c, m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s, c, m;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_w = '0; cfg_s = '0; cfg_c = '0; cfg_m = '0;
    iss_ready = 1'b0;
    @(negedge clk);
    reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_vals("post_reset");

    run_tile(2, 1, 1, 2, 0, -1, 1'b0);
    run_tile(1, 2, 2, 1, 0, -1, 1'b0);
    run_tile(2, 1, 1, 2, 0, 2, 1'b0);
    run_bad(2, 0, 1, 1);
    run_bad(15, 15, 15, 1);
    run_tile(2, 2, 2, 2, 25, -1, 1'b0);
    run_abort(3, 2, 2, 2);
    run_tile(2, 2, 1, 3, 0, -1, 1'b0);
    run_tile(2, 1, 2, 2, 0, -1, 1'b1);
    run_tile(2, 1, 2, 2, 10, -1, 1'b0);
    run_tile(1, 8, 4, 4, 10, -1, 1'b0);
    run_tile(15, 2, 2, 15, 0, -1, 1'b0);
    run_bad(2, 8, 4, 1);
    run_bad(1, 3, 3, 15);
    run_tile(1, 1, 1, 1, 0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      w = $urandom_range(6);
      s = $urandom_range(5);
      c = $urandom_range(5);
      m = $urandom_range(6);
      if (legal(w, s, c, m)) run_tile(w, s, c, m, $urandom_range(50), -1, 1'b0);
      else run_bad(w, s, c, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
